imdct_output_reader: RTL and testbench

//  Read side of the IMDCT output sample RAM filled by the overlap-add stage (addr = sb*18 + slot).

---
 rtl/imdct_output_reader.sv | 121 ++++++++++++
 tb/tb_imdct_output_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imdct_output_reader.sv
// Streams a completed IMDCT granule out of the sample RAM in time-major order,
// applying polyphase frequency inversion, over a valid/ready handshake.
module imdct_output_reader #(
   parameter int NUM_SB    = 32,
   parameter int NUM_SLOTS = 18,
   parameter int DATA_W    = 18,
   parameter int ADDR_W    = 10,
   parameter int FREQ_INV  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [4:0]        sb_idx,
   output logic [4:0]        slot_idx,
   output logic              last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      OUT     = 3'd3,
      FINISH  = 3'd4
   } state_t;

   state_t state, next_state;

   logic [4:0]               sb, slot;
   logic                     handshake;
   logic                     last_pos;
   logic                     invert;
   logic signed [DATA_W-1:0] rd_s;

   // The most negative code has no positive counterpart, so it clamps to max.
   function automatic logic signed [DATA_W-1:0] negate_sat(input logic signed [DATA_W-1:0] x);
      if (x == {1'b1, {(DATA_W-1){1'b0}}})
         return {1'b0, {(DATA_W-1){1'b1}}};
      else
         return -x;
   endfunction

   assign rd_s      = rd_data;
   assign handshake = (state == OUT) && sample_ready;
   assign last_pos  = (sb == 5'(NUM_SB-1)) && (slot == 5'(NUM_SLOTS-1));
   assign invert    = (FREQ_INV != 0) && sb[0] && slot[0];
   assign rd_addr   = ADDR_W'(sb) * ADDR_W'(NUM_SLOTS) + ADDR_W'(slot);

   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sb   <= '0;
         slot <= '0;
      end else if (state == IDLE && start) begin
         sb   <= '0;
         slot <= '0;
      end else if (handshake && !last_pos) begin
         if (sb == 5'(NUM_SB-1)) begin
            sb   <= '0;
            slot <= slot + 5'd1;
         end else begin
            sb <= sb + 5'd1;
         end
      end
   end

   // Output registers are loaded only in CAPTURE so they hold through any stall.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sample_out <= '0;
         sb_idx     <= '0;
         slot_idx   <= '0;
         last       <= 1'b0;
      end else if (state == CAPTURE) begin
         sample_out <= invert ? negate_sat(rd_s) : rd_s;
         sb_idx     <= sb;
         slot_idx   <= slot;
         last       <= last_pos;
      end
   end

   always_comb begin
      next_state   = state;
      rd_en        = 1'b0;
      sample_valid = 1'b0;
      done         = 1'b0;
      busy         = (state != IDLE);
      case (state)
         IDLE:    if (start) next_state = READ;
         READ: begin
            rd_en      = 1'b1;
            next_state = CAPTURE;
         end
         CAPTURE: next_state = OUT;
         OUT: begin
            sample_valid = 1'b1;
            if (sample_ready)
               next_state = last_pos ? FINISH : READ;
         end
         FINISH: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_imdct_output_reader.sv
// Randomised scoreboard bench for imdct_output_reader: a RAM model feeds the DUT,
// expected granules are computed from the ordering/inversion rules and checked by a monitor.
module tb_imdct_output_reader;

   localparam int DATA_W = 18;
   localparam int ADDR_W = 10;
   localparam int MAXV   = 131071;
   localparam int MINV   = -131072;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;
   logic              sample_ready;
   logic [4:0]        sb_idx, slot_idx;
   logic              last, busy, done;

   imdct_output_reader #(
      .NUM_SB(32), .NUM_SLOTS(18), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FREQ_INV(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .sample_out(sample_out), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .sb_idx(sb_idx), .slot_idx(slot_idx),
      .last(last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic signed [DATA_W-1:0] ram [0:1023];
   always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

   typedef struct {
      int v;
      int sb;
      int slot;
      bit lst;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   hs_cnt = 0;
   int   done_cnt = 0;
   int   last_hs_cyc = -10;
   int   mode = 0;   // 0: ready tied high, 1: random ready, 2: bench drives ready
   exp_t e;
   int   got;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (mode == 0) sample_ready = 1'b1;
      else if (mode == 1) sample_ready = 1'($urandom_range(0, 1));
   end

   // Expected stream: slot-major, subband-minor; odd/odd positions negated with clamp.
   task automatic push_granule();
      exp_t x;
      for (int s = 0; s < 18; s++) begin
         for (int b = 0; b < 32; b++) begin
            x.v = ram[b*18 + s];
            if ((b % 2 == 1) && (s % 2 == 1)) x.v = -x.v;
            if (x.v > MAXV) x.v = MAXV;
            x.sb   = b;
            x.slot = s;
            x.lst  = (s == 17) && (b == 31);
            q.push_back(x);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (sample_valid && sample_ready) begin
            vectors++;
            got = $signed(sample_out);
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_sample: got %0d sb %0d slot %0d, required no sample", got, sb_idx, slot_idx);
            end else begin
               e = q.pop_front();
               if (got != e.v || int'(sb_idx) != e.sb || int'(slot_idx) != e.slot || last != e.lst) begin
                  miscompares++;
                  $display("FAIL sample: got v=%0d sb=%0d slot=%0d last=%0b, required v=%0d sb=%0d slot=%0d last=%0b",
                           got, sb_idx, slot_idx, last, e.v, e.sb, e.slot, e.lst);
               end
            end
            hs_cnt++;
            last_hs_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            vectors++;
            if (q.size() != 0 || cyc != last_hs_cyc + 1) begin
               miscompares++;
               $display("FAIL done_timing: pending=%0d cycles_after_last_hs=%0d, required pending=0 cycles=1",
                        q.size(), cyc - last_hs_cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic pulse_start(input bit accept);
      start = 1'b1;
      if (accept) push_granule();
      tick();
      start = 1'b0;
   endtask

   task automatic wait_hs(input int target, input int limit);
      int n = 0;
      while (hs_cnt < target && n < limit) begin
         tick();
         n++;
      end
      if (hs_cnt < target) check("wait_handshakes_timeout", hs_cnt, target);
   endtask

   task automatic wait_done_neg(input int limit);
      int n = 0;
      @(negedge clk);
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("wait_done_timeout", 0, 1);
   endtask

   initial begin
      int h0, d0;
      int snap_v, snap_sb, snap_slot;
      int n;
      rst = 1'b0;
      start = 1'b0;
      sample_ready = 1'b1;
      for (int a = 0; a < 1024; a++) ram[a] = 18'(a);
      repeat (3) tick();

      check("rst_rd_en", rd_en, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sample_out", sample_out, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_sb_idx", sb_idx, 0);
      check("rst_slot_idx", slot_idx, 0);
      rst = 1'b1;
      tick();

      // Ramp RAM, ready high: latency, ignored mid-granule start, start on done ignored.
      h0 = hs_cnt;
      pulse_start(1'b1);
      check("busy_after_start", busy, 1);
      check("read_addr_first", rd_addr, 0);
      check("rd_en_first", rd_en, 1);
      tick();
      check("valid_in_capture", sample_valid, 0);
      tick();
      check("valid_latency3", sample_valid, 1);
      wait_hs(h0 + 200, 2000);
      pulse_start(1'b0);
      wait_done_neg(3000);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("granule1_handshakes", hs_cnt - h0, 576);
      repeat (6) begin
         tick();
         check("idle_after_done_start", {30'd0, busy, sample_valid}, 0);
      end

      // Random data with saturating corners, random backpressure.
      for (int a = 0; a < 576; a++) ram[a] = 18'($urandom);
      ram[19]  = 18'(MINV);
      ram[575] = 18'(MINV);
      ram[0]   = 18'(MINV);
      ram[37]  = 18'(MAXV);
      mode = 1;
      h0 = hs_cnt;
      d0 = done_cnt;
      pulse_start(1'b1);
      wait_done_neg(8000);
      tick();
      check("granule2_handshakes", hs_cnt - h0, 576);
      check("granule2_done_count", done_cnt - d0, 1);

      // Constant 100 with a 10-cycle stall on sample 5.
      for (int a = 0; a < 576; a++) ram[a] = 18'sd100;
      mode = 0;
      h0 = hs_cnt;
      pulse_start(1'b1);
      wait_hs(h0 + 5, 100);
      mode = 2;
      sample_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!sample_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("stall_valid_seen", sample_valid, 1);
      snap_v = $signed(sample_out);
      snap_sb = sb_idx;
      snap_slot = slot_idx;
      check("stall_sample_sb", snap_sb, 5);
      repeat (10) begin
         @(negedge clk);
         check("stall_stable",
               {28'd0, ($signed(sample_out) != snap_v), (int'(sb_idx) != snap_sb),
                (int'(slot_idx) != snap_slot), rd_en}, 0);
      end
      @(posedge clk);
      #1;
      mode = 0;
      sample_ready = 1'b1;
      wait_done_neg(3000);
      tick();
      check("granule3_handshakes", hs_cnt - h0, 576);

      // Reset abort after 100 samples, then a fresh granule.
      for (int a = 0; a < 576; a++) ram[a] = 18'($urandom);
      h0 = hs_cnt;
      pulse_start(1'b1);
      wait_hs(h0 + 100, 1000);
      mode = 2;
      sample_ready = 1'b0;
      rst = 1'b0;
      q.delete();
      d0 = done_cnt;
      tick();
      tick();
      check("abort_busy", busy, 0);
      check("abort_valid", sample_valid, 0);
      rst = 1'b1;
      mode = 0;
      sample_ready = 1'b1;
      ram[0] = 18'sd12345;
      tick();
      check("abort_no_done", done_cnt - d0, 0);
      h0 = hs_cnt;
      pulse_start(1'b1);
      wait_done_neg(3000);
      tick();
      check("granule4_handshakes", hs_cnt - h0, 576);
      check("granule4_done_count", done_cnt - d0, 1);
      check("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
